sha256_block_engine: RTL and testbench
======================================

SHA256_BLOCK_ENGINE -- requirements
Module: sha256_block_engine

Interface
REQ-001 The block SHALL have parameter ROUNDS_PER_CYCLE, default 1, meaning rounds computed per clock; legal values are 1, 2, 4 and 8.
REQ-002 The block SHALL have parameter N_CYC (derived, not overridable), default 64/ROUNDS_PER_CYCLE, meaning round cycles per block.
REQ-003 The block SHALL have port clk, input, width 1: the single clock.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, width 1: a block is offered.
REQ-006 The block SHALL have port in_ready, output, width 1: the engine accepts a block.
REQ-007 The block SHALL have port in_block, input, width 512: message block; bits [511:480] are W0 (big-endian).
REQ-008 The block SHALL have port in_first, input, width 1: start from the IV instead of the chained hash.
REQ-009 The block SHALL have port in_last, input, width 1: a digest is produced after this block.
REQ-010 The block SHALL have port out_valid, output, width 1: digest is valid.
REQ-011 The block SHALL have port out_ready, input, width 1: the consumer takes the digest.
REQ-012 The block SHALL have port digest, output, width 256: [255:224] is H0 and [31:0] is H7.
REQ-013 The block SHALL have port busy, output, width 1: high in every state except IDLE.

Function
REQ-014 The engine SHALL implement states IDLE, ROUND, FINAL and OUT.
REQ-015 In IDLE, in_ready SHALL be 1; in all other states in_ready SHALL be 0.
REQ-016 Acceptance SHALL occur on an edge where in_valid && in_ready; in_block, in_first and in_last SHALL be registered then, and later input changes SHALL have no effect.
REQ-017 On acceptance, working variables a..h SHALL load the IV if in_first=1, otherwise the stored chaining value H; the state SHALL go to ROUND.
REQ-018 ROUND SHALL last exactly N_CYC cycles, with each cycle applying ROUNDS_PER_CYCLE FIPS 180-4 rounds in order t = 0..63.
REQ-019 The message schedule SHALL be a 16-word sliding window: W_t = σ1(W_t-2) + W_t-7 + σ0(W_t-15) + W_t-16, with all additions mod 2^32.
REQ-020 The functions SHALL use rotations, not logical shifts: Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25; σ0 = ROTR7^ROTR18^SHR3; σ1 = ROTR17^ROTR19^SHR10.
REQ-021 The round functions SHALL be Ch = (e&f)^(~e&g) and Maj = (a&b)^(a&c)^(b&c).
REQ-022 In FINAL (1 cycle), H SHALL be updated to H_start + {a..h} word-wise mod 2^32; then the state SHALL go to OUT if the registered last=1, else to IDLE.
REQ-023 Latency: with acceptance on edge E0, FINAL SHALL complete on edge E(N_CYC+1); out_valid or in_ready SHALL be high immediately after that edge.
REQ-024 In OUT, out_valid SHALL be 1 and digest SHALL equal H and stay stable until out_ready=1; the handshake edge SHALL return the state to IDLE.
REQ-025 When out_valid=0, digest SHALL still reflect H, but consumers SHALL ignore it.
REQ-026 in_first=0 after a completed last block SHALL chain from the retained H, without error.
REQ-027 in_valid while busy SHALL be ignored and not latched.
REQ-028 out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-029 Reset SHALL asynchronously force state=IDLE, H=IV (6a09e667 … 5be0cd19), a..h=0, round counter=0, out_valid=0, busy=0 and in_ready=1 after release.
REQ-030 Reset asserted in ROUND, FINAL or OUT SHALL abort the block with no digest emitted and H restored to the IV.

Structure
REQ-031 Package sha256_pkg SHALL hold K[0:63], the IV H0..H7 and the state enum type.
REQ-032 Package sha256_pkg SHALL hold the functions Σ0, Σ1, σ0, σ1, Ch and Maj.
REQ-033 Sub-module sha256_round SHALL be combinational (one round: {a..h}, W, K in; {a..h} out) and SHALL be instantiated ROUNDS_PER_CYCLE times in a chain.
REQ-034 The round counter SHALL be 6 bits, step ROUNDS_PER_CYCLE, and SHALL wrap to 0 on the last ROUND cycle.

Verification
REQ-035 Bench SHALL cover: "abc" padded single block, first=1, last=1 -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-036 Bench SHALL cover: empty message (80000000 then zeros) -> digest e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
REQ-037 Bench SHALL cover: the 56-byte "abcdbcdecdef…nopq" message as two blocks (first=1,last=0 then first=0,last=1) -> digest 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, with no out_valid after block 1.
REQ-038 Bench SHALL cover: for each ROUNDS_PER_CYCLE in {1,2,4,8}, "abc" -> out_valid rises exactly 66/34/18/10 cycles after acceptance, with the digest identical.
REQ-039 Bench SHALL cover: out_ready held low for 10 cycles in OUT -> digest stable, in_ready=0, and in_valid pulses not accepted.
REQ-040 Bench SHALL cover: reset pulsed at ROUND cycle 20, then "abc" with first=0 -> correct "abc" digest (H was restored to the IV).

Source files
------------

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, engine state type and round helper functions
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_OUT
    } state_t;

    localparam logic [0:63][31:0] K = {
        256'h428a2f98_71374491_b5c0fbcf_e9b5dba5_3956c25b_59f111f1_923f82a4_ab1c5ed5,
        256'hd807aa98_12835b01_243185be_550c7dc3_72be5d74_80deb1fe_9bdc06a7_c19bf174,
        256'he49b69c1_efbe4786_0fc19dc6_240ca1cc_2de92c6f_4a7484aa_5cb0a9dc_76f988da,
        256'h983e5152_a831c66d_b00327c8_bf597fc7_c6e00bf3_d5a79147_06ca6351_14292967,
        256'h27b70a85_2e1b2138_4d2c6dfc_53380d13_650a7354_766a0abb_81c2c92e_92722c85,
        256'ha2bfe8a1_a81a664b_c24b8b70_c76c51a3_d192e819_d6990624_f40e3585_106aa070,
        256'h19a4c116_1e376c08_2748774c_34b0bcb5_391c0cb3_4ed8aa4a_5b9cca4f_682e6ff3,
        256'h748f82ee_78a5636f_84c87814_8cc70208_90befffa_a4506ceb_bef9a3f7_c67178f2
    };

    // H0 in the top word, H7 in the bottom word
    localparam logic [255:0] IV =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 round over the packed working state {a..h}
import sha256_pkg::*;

module sha256_round (
    input  logic [255:0] state_in,
    input  logic [31:0]  w,
    input  logic [31:0]  k,
    output logic [255:0] state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;
    assign t1 = h + bsig1(e) + ch(e, f, g) + k + w;
    assign t2 = bsig0(a) + maj(a, b, c);
    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_block_engine.sv
// rtl/sha256_block_engine.sv - SHA-256 block compression engine with chained hash and digest handshake
import sha256_pkg::*;

module sha256_block_engine #(
    parameter int  ROUNDS_PER_CYCLE = 1,
    localparam int N_CYC            = 64 / ROUNDS_PER_CYCLE
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] digest,
    output logic         busy
);

    localparam logic [5:0] LAST_CNT = 6'((N_CYC - 1) * ROUNDS_PER_CYCLE);

    state_t       state;
    state_t       state_nxt;
    logic [255:0] h_reg;
    logic [255:0] work;
    logic [255:0] round_out;
    logic [255:0] h_sum;
    logic [511:0] win;
    logic [511:0] win_nxt;
    logic [5:0]   rnd_cnt;
    logic         last_q;

    // win holds W_t..W_t+15 with W_t in the top word; slide it by ROUNDS_PER_CYCLE words per cycle
    always_comb begin : p_sched
        logic [31:0] ext [0:15+ROUNDS_PER_CYCLE];
        for (int j = 0; j < 16; j++) begin
            ext[j] = win[511-32*j -: 32];
        end
        for (int m = 0; m < ROUNDS_PER_CYCLE; m++) begin
            ext[16+m] = ssig1(ext[14+m]) + ext[9+m] + ssig0(ext[1+m]) + ext[m];
        end
        win_nxt = '0;
        for (int j = 0; j < 16; j++) begin
            win_nxt[511-32*j -: 32] = ext[j+ROUNDS_PER_CYCLE];
        end
    end

    for (genvar r = 0; r < ROUNDS_PER_CYCLE; r++) begin : g_rnd
        logic [255:0] st_i;
        logic [255:0] st_o;
        logic [5:0]   k_idx;
        if (r == 0) begin : g_head
            assign st_i = work;
        end else begin : g_link
            assign st_i = g_rnd[r-1].st_o;
        end
        assign k_idx = rnd_cnt + 6'(r);
        sha256_round u_round (
            .state_in  (st_i),
            .w         (win[511-32*r -: 32]),
            .k         (K[k_idx]),
            .state_out (st_o)
        );
    end

    assign round_out = g_rnd[ROUNDS_PER_CYCLE-1].st_o;

    always_comb begin
        h_sum = '0;
        for (int j = 0; j < 8; j++) begin
            h_sum[255-32*j -: 32] = h_reg[255-32*j -: 32] + work[255-32*j -: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                if (rnd_cnt == LAST_CNT) state_nxt = ST_FINAL;
            end
            ST_FINAL: begin
                state_nxt = last_q ? ST_OUT : ST_IDLE;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A first block replaces H with the IV so FINAL always adds onto h_reg
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_reg   <= IV;
            work    <= '0;
            win     <= '0;
            rnd_cnt <= '0;
            last_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work   <= in_first ? IV : h_reg;
                        win    <= in_block;
                        last_q <= in_last;
                        if (in_first) h_reg <= IV;
                    end
                end
                ST_ROUND: begin
                    work    <= round_out;
                    win     <= win_nxt;
                    rnd_cnt <= rnd_cnt + 6'(ROUNDS_PER_CYCLE);
                end
                ST_FINAL: begin
                    h_reg <= h_sum;
                end
                default: ;
            endcase
        end
    end

    assign digest = h_reg;

endmodule

// File: tb/tb_sha256_block_engine.sv
// tb/tb_sha256_block_engine.sv - randomized and known-answer bench for sha256_block_engine at 1/2/4/8 rounds per cycle
module tb_sha256_block_engine;

    localparam int NI = 4;

    localparam logic [255:0] IV_T =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [0:63][31:0] KT = {
        256'h428a2f98_71374491_b5c0fbcf_e9b5dba5_3956c25b_59f111f1_923f82a4_ab1c5ed5,
        256'hd807aa98_12835b01_243185be_550c7dc3_72be5d74_80deb1fe_9bdc06a7_c19bf174,
        256'he49b69c1_efbe4786_0fc19dc6_240ca1cc_2de92c6f_4a7484aa_5cb0a9dc_76f988da,
        256'h983e5152_a831c66d_b00327c8_bf597fc7_c6e00bf3_d5a79147_06ca6351_14292967,
        256'h27b70a85_2e1b2138_4d2c6dfc_53380d13_650a7354_766a0abb_81c2c92e_92722c85,
        256'ha2bfe8a1_a81a664b_c24b8b70_c76c51a3_d192e819_d6990624_f40e3585_106aa070,
        256'h19a4c116_1e376c08_2748774c_34b0bcb5_391c0cb3_4ed8aa4a_5b9cca4f_682e6ff3,
        256'h748f82ee_78a5636f_84c87814_8cc70208_90befffa_a4506ceb_bef9a3f7_c67178f2
    };

    localparam logic [255:0] D_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_TWO =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TWO1  = {
        256'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b,
        256'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000
    };
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_first;
    logic         in_last;
    logic         out_ready;
    logic [511:0] in_block;
    logic         in_ready_v  [NI];
    logic         out_valid_v [NI];
    logic         busy_v      [NI];
    logic [255:0] digest_v    [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sha256_block_engine #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .in_block  (in_block),
            .in_first  (in_first),
            .in_last   (in_last),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .digest    (digest_v[g]),
            .busy      (busy_v[g])
        );
    end

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    bit           rand_or = 1'b0;
    logic [255:0] mh       [NI];
    logic [255:0] exp_d    [NI][64];
    int           exp_c    [NI][64];
    int           wr       [NI];
    int           rd       [NI];
    logic         prev_ov  [NI];
    logic [255:0] last_dig [NI];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression: full 64-word schedule array, then 64 rounds, then feed-forward
    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1;
        logic [31:0]  t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return res;
    endfunction

    // Latency is counted in falling edges from the one that sees the handshake to the one that sees out_valid
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                mh[i]      = IV_T;
                rd[i]      = 0;
                wr[i]      = 0;
                prev_ov[i] = 1'b0;
            end else begin
                chk("ready_vs_busy", in_ready_v[i], !busy_v[i]);
                if (out_valid_v[i]) begin
                    if (rd[i] == wr[i]) begin
                        chk("spurious_out_valid", out_valid_v[i], 1'b0);
                    end else begin
                        chk("digest_vs_model", digest_v[i], exp_d[i][rd[i] & 63]);
                        if (!prev_ov[i]) begin
                            chk("out_latency", cyc, exp_c[i][rd[i] & 63]);
                            last_dig[i] = digest_v[i];
                        end
                        if (out_ready) rd[i]++;
                    end
                end
                if (in_valid && in_ready_v[i]) begin
                    mh[i] = compress(in_first ? IV_T : mh[i], in_block);
                    if (in_last) begin
                        exp_d[i][wr[i] & 63] = mh[i];
                        exp_c[i][wr[i] & 63] = cyc + (64 >> i) + 2;
                        wr[i]++;
                    end
                end
                prev_ov[i] = out_valid_v[i];
            end
        end
    end

    function automatic bit all_ready();
        for (int i = 0; i < NI; i++) if (in_ready_v[i] !== 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit all_done();
        for (int i = 0; i < NI; i++) if (rd[i] != wr[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit all_ov();
        for (int i = 0; i < NI; i++) if (out_valid_v[i] !== 1'b1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int j = 0; j < 16; j++) b[511-32*j -: 32] = $urandom();
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_or) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [511:0] blk, input logic first, input logic last);
        int n;
        n = 0;
        step();
        while (!all_ready() && n < 300) begin
            step();
            n++;
        end
        chk("send_ready_timeout", all_ready(), 1'b1);
        in_block = blk;
        in_first = first;
        in_last  = last;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_block = rand_block();
        in_first = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(all_ready() && all_done()) && n < 400) begin
            step();
            n++;
        end
        for (int i = 0; i < NI; i++) chk("drain_outstanding", rd[i], wr[i]);
    endtask

    task automatic check_idle();
        for (int i = 0; i < NI; i++) begin
            chk("idle_in_ready", in_ready_v[i], 1'b1);
            chk("idle_busy", busy_v[i], 1'b0);
            chk("idle_out_valid", out_valid_v[i], 1'b0);
            chk("idle_digest_iv", digest_v[i], IV_T);
        end
    endtask

    task automatic check_last(input string nm, input logic [255:0] exp);
        for (int i = 0; i < NI; i++) chk(nm, last_dig[i], exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_block  = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_idle();

        send(B_ABC, 1'b1, 1'b1);
        drain();
        check_last("abc_digest", D_ABC);

        send(B_EMPTY, 1'b1, 1'b1);
        drain();
        check_last("empty_digest", D_EMPTY);

        send(B_TWO1, 1'b1, 1'b0);
        send(B_TWO2, 1'b0, 1'b1);
        drain();
        check_last("two_block_digest", D_TWO);

        // Consumer stalls for 10 cycles in OUT while in_valid keeps pulsing
        out_ready = 1'b0;
        send(B_ABC, 1'b1, 1'b1);
        n = 0;
        while (!all_ov() && n < 200) begin
            step();
            n++;
        end
        chk("stall_out_valid_timeout", all_ov(), 1'b1);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            in_block = rand_block();
            in_first = 1'b1;
            in_last  = 1'b1;
            step();
            for (int i = 0; i < NI; i++) begin
                chk("stall_in_ready", in_ready_v[i], 1'b0);
                chk("stall_out_valid", out_valid_v[i], 1'b1);
                chk("stall_digest", digest_v[i], D_ABC);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        rand_or = 1'b1;
        for (int b = 0; b < 12; b++) begin
            send(rand_block(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        send(rand_block(), 1'b0, 1'b1);
        drain();
        rand_or   = 1'b0;
        out_ready = 1'b1;

        // Abort mid-ROUND, then chain from H: the result must be the plain "abc" digest
        send(rand_block(), 1'b1, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle();
        send(B_ABC, 1'b0, 1'b1);
        drain();
        check_last("abc_after_reset", D_ABC);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
